// File: rtl/npu_pkg.sv
// Shared constants, state encoding and accumulator-limit helpers for NPU processing elements.
package npu_pkg;

    localparam int unsigned NPU_DATA_W = 8;
    localparam int unsigned NPU_ACC_W  = 32;
    // Widest accumulator the limit helpers can describe; callers size-cast down to their ACC_W.
    localparam int unsigned MAX_ACC_W  = 64;

    typedef enum logic {
        PE_IDLE  = 1'b0,
        PE_ACCUM = 1'b1
    } pe_state_t;

    // Largest representable accumulator value for width w.
    function automatic logic [MAX_ACC_W-1:0] acc_max(input int unsigned w, input bit is_signed);
        logic [MAX_ACC_W-1:0] ones;
        ones = '1;
        return ones >> (MAX_ACC_W - w + (is_signed ? 32'd1 : 32'd0));
    endfunction

    // Smallest representable accumulator value for width w (bit pattern within the low w bits).
    function automatic logic [MAX_ACC_W-1:0] acc_min(input int unsigned w, input bit is_signed);
        logic [MAX_ACC_W-1:0] one;
        one = MAX_ACC_W'(1);
        return is_signed ? (one << (w - 32'd1)) : '0;
    endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Combinational multiply-accumulate step: product extension plus wrapping or saturating add.
module pe_mac_unit
    import npu_pkg::*;
#(
    parameter int unsigned DATA_W   = NPU_DATA_W,
    parameter int unsigned ACC_W    = NPU_ACC_W,
    parameter bit          SIGNED   = 1'b1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ACC_W-1:0]  acc,
    output logic [ACC_W-1:0]  acc_next,
    output logic              sat_event
);

    localparam int unsigned       PROD_W  = 2 * DATA_W;
    localparam logic [ACC_W-1:0]  SAT_MAX = ACC_W'(acc_max(ACC_W, SIGNED));
    localparam logic [ACC_W-1:0]  SAT_MIN = ACC_W'(acc_min(ACC_W, SIGNED));

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W:0]    sum_w;
    logic [ACC_W-1:0]  sum;
    logic              ovf;

    // Multiply at full product width, extend to accumulator width, add and clamp on overflow.
    always_comb begin
        // Operands are extended to the product width so the low PROD_W bits of an
        // unsigned multiply equal the two's-complement product in signed mode.
        a_ext = SIGNED ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
        b_ext = SIGNED ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
        prod  = a_ext * b_ext;

        prod_ext = SIGNED ? ACC_W'($signed(prod)) : ACC_W'(prod);

        sum_w = {1'b0, acc} + {1'b0, prod_ext};
        sum   = sum_w[ACC_W-1:0];

        if (SIGNED) begin
            ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        end else begin
            ovf = sum_w[ACC_W];
        end

        acc_next  = sum;
        sat_event = 1'b0;
        if (SATURATE && ovf) begin
            sat_event = 1'b1;
            // Signed overflow can only occur with like-signed operands; the accumulator sign picks the rail.
            acc_next  = (SIGNED && acc[ACC_W-1]) ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/pe_mac_stream.sv
// Output-stationary systolic PE: operand forwarding, per-tile accumulation FSM,
// single-entry ready/valid result buffer and sticky overrun/saturation flags.
module pe_mac_stream
    import npu_pkg::*;
#(
    parameter int unsigned DATA_W   = NPU_DATA_W,
    parameter int unsigned ACC_W    = NPU_ACC_W,
    parameter bit          SIGNED   = 1'b1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_north,
    input  logic [DATA_W-1:0] in_west,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              clr_flags,
    output logic [DATA_W-1:0] out_south,
    output logic [DATA_W-1:0] out_east,
    output logic              out_valid,
    output logic              out_last,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy,
    output logic              overrun,
    output logic              sat
);

    logic [DATA_W-1:0] south_q;
    logic [DATA_W-1:0] east_q;
    logic              fwd_valid_q;
    logic              fwd_last_q;

    pe_state_t         state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic              rvalid_q, rvalid_d;
    logic              overrun_q, overrun_d;
    logic              sat_q, sat_d;

    logic [ACC_W-1:0]  mac_next;
    logic              mac_sat;
    logic              publish;
    logic              transfer;

    pe_mac_unit #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_mac (
        .a         (in_north),
        .b         (in_west),
        .acc       (acc_q),
        .acc_next  (mac_next),
        .sat_event (mac_sat)
    );

    // Operand and sideband forwarding to south/east neighbours, one stage, no backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            south_q     <= '0;
            east_q      <= '0;
            fwd_valid_q <= 1'b0;
            fwd_last_q  <= 1'b0;
        end else begin
            south_q     <= in_north;
            east_q      <= in_west;
            fwd_valid_q <= in_valid;
            fwd_last_q  <= in_last;
        end
    end

    // Tile FSM: accumulate valid pairs, publish on the last one; acc is zero whenever in IDLE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        publish = 1'b0;
        case (state_q)
            PE_IDLE: begin
                if (in_valid) begin
                    if (in_last) begin
                        publish = 1'b1;
                    end else begin
                        acc_d   = mac_next;
                        state_d = PE_ACCUM;
                    end
                end
            end
            PE_ACCUM: begin
                if (in_valid) begin
                    if (in_last) begin
                        publish = 1'b1;
                        acc_d   = '0;
                        state_d = PE_IDLE;
                    end else begin
                        acc_d   = mac_next;
                    end
                end
            end
            default: begin
                state_d = PE_IDLE;
                acc_d   = '0;
            end
        endcase
    end

    // Result buffer handshake and sticky flags; a set event outranks clr_flags.
    always_comb begin
        transfer  = rvalid_q && result_ready;
        result_d  = result_q;
        rvalid_d  = rvalid_q;
        overrun_d = overrun_q;
        sat_d     = sat_q;

        if (publish) begin
            result_d = mac_next;
            rvalid_d = 1'b1;
        end else if (transfer) begin
            rvalid_d = 1'b0;
        end

        if (clr_flags) begin
            overrun_d = 1'b0;
            sat_d     = 1'b0;
        end
        if (publish && rvalid_q && !result_ready) begin
            overrun_d = 1'b1;
        end
        if (SATURATE && in_valid && mac_sat) begin
            sat_d = 1'b1;
        end
    end

    // State, accumulator, result and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PE_IDLE;
            acc_q     <= '0;
            result_q  <= '0;
            rvalid_q  <= 1'b0;
            overrun_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            rvalid_q  <= rvalid_d;
            overrun_q <= overrun_d;
            sat_q     <= sat_d;
        end
    end

    assign out_south    = south_q;
    assign out_east     = east_q;
    assign out_valid    = fwd_valid_q;
    assign out_last     = fwd_last_q;
    assign result       = result_q;
    assign result_valid = rvalid_q;
    assign busy         = (state_q == PE_ACCUM);
    assign overrun      = overrun_q;
    assign sat          = sat_q;

endmodule

// File: tb/tb_pe_mac_stream.sv
// Scoreboard bench for pe_mac_stream: three instances (unsigned/wrap, signed/wrap,
// signed/saturating 16-bit); expected results are queued at stimulus time and
// popped by per-instance monitors on every result transfer.
module tb_pe_mac_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] north, west;
    logic       last, clr;
    logic       v0, v1, v2;
    logic       rdy0, rdy1, rdy2;

    logic [7:0]  s0, e0, s1, e1, s2, e2;
    logic        ov0, ol0, ov1, ol1, ov2, ol2;
    logic [31:0] r0, r1;
    logic [15:0] r2;
    logic        rv0, rv1, rv2, bz0, bz1, bz2;
    logic        orun0, orun1, orun2, st0, st1, st2;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [15:0] q2[$];

    pe_mac_stream #(.DATA_W(8), .ACC_W(32), .SIGNED(1'b0), .SATURATE(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_north(north), .in_west(west), .in_valid(v0), .in_last(last),
        .clr_flags(clr), .out_south(s0), .out_east(e0), .out_valid(ov0), .out_last(ol0),
        .result(r0), .result_valid(rv0), .result_ready(rdy0), .busy(bz0), .overrun(orun0), .sat(st0)
    );

    pe_mac_stream #(.DATA_W(8), .ACC_W(32), .SIGNED(1'b1), .SATURATE(1'b0)) u1 (
        .clk(clk), .rst(rst), .in_north(north), .in_west(west), .in_valid(v1), .in_last(last),
        .clr_flags(clr), .out_south(s1), .out_east(e1), .out_valid(ov1), .out_last(ol1),
        .result(r1), .result_valid(rv1), .result_ready(rdy1), .busy(bz1), .overrun(orun1), .sat(st1)
    );

    pe_mac_stream #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1), .SATURATE(1'b1)) u2 (
        .clk(clk), .rst(rst), .in_north(north), .in_west(west), .in_valid(v2), .in_last(last),
        .clr_flags(clr), .out_south(s2), .out_east(e2), .out_valid(ov2), .out_last(ol2),
        .result(r2), .result_valid(rv2), .result_ready(rdy2), .busy(bz2), .overrun(orun2), .sat(st2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] n, input logic [7:0] w, input logic l);
        north = n;
        west  = w;
        last  = l;
    endtask

    // Result monitors: every transfer must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rv0 && rdy0) begin
            n_chk++;
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL u0_result: unexpected transfer 0x%0h with empty queue", r0);
            end else begin
                e = q0.pop_front();
                if (r0 !== e) begin
                    n_fail++;
                    $display("FAIL u0_result: got 0x%0h expected 0x%0h", r0, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        if (rv1 && rdy1) begin
            n_chk++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL u1_result: unexpected transfer 0x%0h with empty queue", r1);
            end else begin
                e = q1.pop_front();
                if (r1 !== e) begin
                    n_fail++;
                    $display("FAIL u1_result: got 0x%0h expected 0x%0h", r1, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (rv2 && rdy2) begin
            n_chk++;
            if (q2.size() == 0) begin
                n_fail++;
                $display("FAIL u2_result: unexpected transfer 0x%0h with empty queue", r2);
            end else begin
                e = q2.pop_front();
                if (r2 !== e) begin
                    n_fail++;
                    $display("FAIL u2_result: got 0x%0h expected 0x%0h", r2, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
        rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        put(8'd0, 8'd0, 1'b0);
        step(); step();

        // Reset state of every instance
        chk("rst_u0_ctl", {s0, e0, ov0, ol0, rv0, bz0, orun0, st0}, 32'd0);
        chk("rst_u0_res", r0, 32'd0);
        chk("rst_u1_ctl", {s1, e1, ov1, ol1, rv1, bz1, orun1, st1}, 32'd0);
        chk("rst_u1_res", r1, 32'd0);
        chk("rst_u2_ctl", {s2, e2, ov2, ol2, rv2, bz2, orun2, st2}, 32'd0);
        chk("rst_u2_res", {16'd0, r2}, 32'd0);
        rst = 1'b0;

        // Unsigned 3-pair tile: 6 + 20 + 6 = 32
        v0 = 1'b1; put(8'd2, 8'd3, 1'b0); step();
        chk("t1_busy_c1", bz0, 1); chk("t1_fwd_s", s0, 2); chk("t1_fwd_e", e0, 3); chk("t1_fwd_v", ov0, 1);
        put(8'd4, 8'd5, 1'b0); step();
        chk("t1_busy_c2", bz0, 1); chk("t1_rv_early", rv0, 0);
        q0.push_back(32'd32); put(8'd1, 8'd6, 1'b1); step();
        chk("t1_rv", rv0, 1); chk("t1_busy_done", bz0, 0); chk("t1_fwd_last", ol0, 1);
        v0 = 1'b0; put(8'd0, 8'd0, 1'b0); step();
        chk("t1_rv_drop", rv0, 0);

        // Signed: -12 + 10 = -2, then lone (-1)*(-1) = 1 from IDLE
        v1 = 1'b1; put(8'hFD, 8'h04, 1'b0); step();
        chk("t2_busy", bz1, 1);
        q1.push_back(32'hFFFF_FFFE); put(8'd2, 8'd5, 1'b1); step();
        chk("t2_rv", rv1, 1); chk("t2_idle", bz1, 0);
        q1.push_back(32'd1); put(8'hFF, 8'hFF, 1'b1); step();
        chk("t2_lone_rv", rv1, 1); chk("t2_lone_idle", bz1, 0);
        v1 = 1'b0; put(8'd0, 8'd0, 1'b0); step();
        chk("t2_rv_drop", rv1, 0); chk("t2_no_sat", st1, 0);

        // Saturating 16-bit: 16129 x4 clamps at 32767 on the third pair
        v2 = 1'b1; put(8'd127, 8'd127, 1'b0); step(); step();
        chk("t3_sat_pre", st2, 0);
        step();
        chk("t3_sat_set", st2, 1);
        q2.push_back(16'h7FFF); last = 1'b1; step();
        chk("t3_rv", rv2, 1); chk("t3_idle", bz2, 0);
        v2 = 1'b0; put(8'd0, 8'd0, 1'b0); clr = 1'b1; step();
        chk("t3_sat_clr", st2, 0);
        clr = 1'b0;

        // Bubbles, forwarding latency, in_last without in_valid
        v0 = 1'b1; put(8'd7, 8'd2, 1'b0); #1;
        chk("t4_fwd_not_yet", s0, 0);
        step();
        chk("t4_fwd_s", s0, 7); chk("t4_fwd_e", e0, 2); chk("t4_fwd_v", ov0, 1); chk("t4_fwd_l", ol0, 0);
        v0 = 1'b0; put(8'd9, 8'd1, 1'b1); step();
        chk("t4_bub_s", s0, 9); chk("t4_bub_v", ov0, 0); chk("t4_bub_l", ol0, 1); chk("t4_lone_last_busy", bz0, 1);
        put(8'd0, 8'd0, 1'b0); step(); step();
        chk("t4_hold_busy", bz0, 1); chk("t4_hold_rv", rv0, 0);
        v0 = 1'b1; q0.push_back(32'd23); put(8'd3, 8'd3, 1'b1); step();
        chk("t4_rv", rv0, 1); chk("t4_idle", bz0, 0); chk("t4_fwd_v2", ov0, 1); chk("t4_fwd_l2", ol0, 1);
        v0 = 1'b0; put(8'd0, 8'd0, 1'b0); step();

        // Backpressure: 10 overwritten by 20 -> overrun; transfer coincides with publish of 5
        rdy0 = 1'b0; v0 = 1'b1; put(8'd1, 8'd4, 1'b0); step();
        put(8'd2, 8'd3, 1'b1); step();
        chk("t5_res10", r0, 32'd10); chk("t5_orun_pre", orun0, 0);
        put(8'd4, 8'd5, 1'b1); step();
        chk("t5_res20", r0, 32'd20); chk("t5_orun_set", orun0, 1); chk("t5_rv_held", rv0, 1);
        q0.push_back(32'd20); q0.push_back(32'd5);
        rdy0 = 1'b1; put(8'd1, 8'd5, 1'b1); step();
        chk("t5_res5", r0, 32'd5); chk("t5_rv_stay", rv0, 1); chk("t5_orun_kept", orun0, 1);
        v0 = 1'b0; put(8'd0, 8'd0, 1'b0); step();
        chk("t5_rv_drop", rv0, 0); chk("t5_orun_sticky", orun0, 1);
        clr = 1'b1; step();
        chk("t5_orun_clr", orun0, 0);
        clr = 1'b0;

        // Reset mid-tile with pending result, then fresh tile
        rdy0 = 1'b0; v0 = 1'b1; put(8'd3, 8'd3, 1'b1); step();
        put(8'd2, 8'd3, 1'b0); step();
        put(8'd4, 8'd2, 1'b0); step();
        chk("t6_busy", bz0, 1); chk("t6_pending", rv0, 1);
        rst = 1'b1; put(8'd5, 8'd5, 1'b1); step();
        rst = 1'b0;
        chk("t6_rst_ctl", {s0, e0, ov0, ol0, rv0, bz0, orun0, st0}, 32'd0);
        chk("t6_rst_res", r0, 32'd0);
        rdy0 = 1'b1; q0.push_back(32'd6); put(8'd2, 8'd3, 1'b1); step();
        chk("t6_fresh_rv", rv0, 1);
        v0 = 1'b0; put(8'd0, 8'd0, 1'b0); step(); step();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_mac_stream.md
Name: pe_mac_stream

Overview:
Parametrised, output-stationary systolic processing element for the NPU array. It is the next generation of the basic PE. Operands flow north→south and west→east through one register stage each. Products accumulate locally per tile, framed by valid/last sideband. A completed tile's sum is handed off through a ready/valid result port, so the next tile can accumulate without stalling the array. Signedness and saturation are selectable per instance.

Parameters:
DATA_W, 8, operand width (north/west)
ACC_W, 32, accumulator/result width; must be ≥ 2*DATA_W
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned
SATURATE, 0, 1 = clamp accumulator at ACC_W min/max, 0 = wrap modulo 2^ACC_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
in_north  in  DATA_W  operand from north neighbour
in_west  in  DATA_W  operand from west neighbour
in_valid  in  1  operands valid this cycle
in_last  in  1  final operand pair of tile; qualified by in_valid
clr_flags  in  1  clears sticky overrun/sat flags
out_south  out  DATA_W  registered in_north
out_east  out  DATA_W  registered in_west
out_valid  out  1  registered in_valid
out_last  out  1  registered in_last
result  out  ACC_W  completed tile sum, stable while result_valid
result_valid  out  1  result available
result_ready  in  1  downstream accepts result
busy  out  1  tile accumulation in progress (state ACCUM)
overrun  out  1  sticky: unread result overwritten
sat  out  1  sticky: saturation occurred (always 0 if SATURATE=0)

Behaviour:
- Reset: every output goes to 0, accumulator goes to 0, state goes to IDLE. rst wins over all other inputs in the same cycle. Reset mid-tile discards the partial sum and any pending result.
- Forwarding: out_south, out_east, out_valid and out_last load in_north, in_west, in_valid and in_last every cycle, unconditionally. Latency is 1 cycle. There is no backpressure on the operand path.
- Product: DATA_W×DATA_W → 2*DATA_W. It is sign-extended if SIGNED=1 and zero-extended otherwise, then added to the accumulator at ACC_W width.
- SATURATE=1: on signed overflow, clamp to max/min for the chosen signedness and set sat. In unsigned mode, clamp to 2^ACC_W−1.
- State machine:
  - IDLE: accumulator = 0.
    - in_valid & !in_last → acc := prod, go to ACCUM.
    - in_valid & in_last → single-element tile; publish prod, stay IDLE.
  - ACCUM:
    - in_valid & !in_last → acc := acc+prod.
    - in_valid & in_last → publish acc+prod, acc := 0, go to IDLE.
    - !in_valid → hold (bubbles allowed).
  - in_last without in_valid is ignored.
- Publish: result loads on the edge after the in_valid&in_last cycle, and result_valid=1 on that same edge. Latency from last operand to result_valid is 1 cycle.
- Result handshake: a transfer occurs on a cycle with result_valid & result_ready.
  - Transfer without a new publish → result_valid := 0.
  - Publish in the same cycle as a transfer → new value loaded, result_valid stays 1, no overrun.
  - Publish while result_valid & !result_ready → result overwritten and overrun := 1.
- Flags: overrun and sat stay set until clr_flags or rst. If clr_flags and a new set event occur in the same cycle, the set wins.
- busy = (state == ACCUM).

Decomposition:
- Package npu_pkg holds:
  - default DATA_W/ACC_W constants,
  - enum pe_state_t {PE_IDLE, PE_ACCUM},
  - ACC_MAX/ACC_MIN helper functions parametrised on width and signedness.
- Sub-module pe_mac_unit is combinational. It takes a, b and acc, returns acc_next and sat_event, and contains the multiply, extension and wrap/saturating add. It is reused by future weight-stationary variants.
- pe_mac_stream itself holds the forwarding registers, the FSM, the result buffer and the flags.

Test Plan:
1. Defaults, unsigned/wrap: pairs (2,3),(4,5),(1,6) on consecutive cycles, last on third → result=32, result_valid one cycle after the third pair; busy=1 during cycles 2–3.
2. SIGNED=1: (−3,4),(2,5) with last → result=32'hFFFF_FFFE (−2); then a lone pair (−1,−1) with last from IDLE → result=1.
3. SATURATE=1, ACC_W=16, SIGNED=1: four pairs (127,127) → clamp at 32767, sat=1; clr_flags clears sat.
4. Bubbles and forwarding: valid pairs separated by 2 idle cycles → out_* mirror inputs delayed exactly 1 cycle; accumulator holds across bubbles; in_last without in_valid is ignored.
5. Backpressure: hold result_ready=0, complete tiles summing to 10 then 20 → result=20, overrun=1. Then result_ready=1 coincident with a third publish of 5 → result=5, result_valid stays 1, overrun unchanged.
6. rst asserted mid-tile after partial sum 14 with a pending result → all outputs 0 next cycle; a fresh tile (2,3) then gives result=6.
